// File: rtl/axi4_lite_slave_write_responder.sv
// axi4_lite_slave_write_responder: AXI4-Lite AW/W/B to single-cycle register-file write strobe
module axi4_lite_slave_write_responder #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS = 16,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [ADDRESS_WIDTH-1:0]      awaddr,
    input  logic                          awvalid,
    output logic                          awready,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [DATA_WIDTH/8-1:0]       wstrb,
    input  logic                          wvalid,
    output logic                          wready,
    output logic [1:0]                    bresp,
    output logic                          bvalid,
    input  logic                          bready,
    output logic                          reg_wr_en,
    output logic [$clog2(NUM_REGS)-1:0]   reg_wr_idx,
    output logic [DATA_WIDTH-1:0]         reg_wr_data,
    output logic [DATA_WIDTH/8-1:0]       reg_wr_strb,
    input  logic                          reg_wr_err
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int SB = $clog2(SW);
    localparam int IW = $clog2(NUM_REGS);
    typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;
    state_t state, state_n;
    logic up, aw_full, w_full, aw_hs, w_hs, both, start, legal, legal_q;
    logic [ADDRESS_WIDTH-1:0] aw_addr, addr_n, off;
    logic [DATA_WIDTH-1:0] w_data, data_n;
    logic [SW-1:0] w_strb, strb_n;
    assign awready = up & (state == IDLE) & ~aw_full;
    assign wready = up & (state == IDLE) & ~w_full;
    assign aw_hs = awvalid & awready;
    assign w_hs = wvalid & wready;
    assign addr_n = aw_hs ? awaddr : aw_addr;
    assign data_n = w_hs ? wdata : w_data;
    assign strb_n = w_hs ? wstrb : w_strb;
    assign both = (aw_full | aw_hs) & (w_full | w_hs);
    assign start = (state == IDLE) & both;
    assign off = addr_n - BASE_ADDR;
    assign legal = (off[SB-1:0] == '0) && ((off >> SB) < ADDRESS_WIDTH'(NUM_REGS));
    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (start) state_n = WRITE;
        else if (state == WRITE) state_n = RESP;
        else if (state == RESP && bready) state_n = IDLE;
    end
    always_ff @(posedge aclk) begin
        if (areset) begin
            up <= 1'b0;
            aw_full <= 1'b0;
            w_full <= 1'b0;
            aw_addr <= '0;
            w_data <= '0;
            w_strb <= '0;
            legal_q <= 1'b0;
            bvalid <= 1'b0;
            bresp <= 2'b00;
            reg_wr_en <= 1'b0;
            reg_wr_idx <= '0;
            reg_wr_data <= '0;
            reg_wr_strb <= '0;
        end else begin
            up <= 1'b1;
            reg_wr_en <= start & legal;
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_addr <= awaddr;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end
            if (start) begin
                legal_q <= legal;
                reg_wr_idx <= off[SB +: IW];
                reg_wr_data <= data_n;
                reg_wr_strb <= strb_n;
            end
            if (state == WRITE) begin
                bvalid <= 1'b1;
                bresp <= (~legal_q | reg_wr_err) ? 2'b10 : 2'b00;
            end
            if (state == RESP && bready) begin
                bvalid <= 1'b0;
                aw_full <= 1'b0;
                w_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi4_lite_slave_write_responder.sv
// tb_axi4_lite_slave_write_responder: directed and randomized checks against a cycle-stamped transaction model
module tb_axi4_lite_slave_write_responder;
    logic clk = 1'b0;
    logic areset = 1'b1;
    logic [31:0] awaddr = '0;
    logic awvalid = 1'b0;
    logic awready;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = '0;
    logic wvalid = 1'b0;
    logic wready;
    logic [1:0] bresp;
    logic bvalid;
    logic bready = 1'b1;
    logic reg_wr_en;
    logic [3:0] reg_wr_idx;
    logic [31:0] reg_wr_data;
    logic [3:0] reg_wr_strb;
    logic reg_wr_err = 1'b0;
    int checks = 0;
    int errors = 0;
    axi4_lite_slave_write_responder dut (
        .aclk(clk), .areset(areset), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bresp(bresp),
        .bvalid(bvalid), .bready(bready), .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx),
        .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb), .reg_wr_err(reg_wr_err)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    int done_at = -1;
    bit m_init = 0, up = 0, ha = 0, hw = 0, in_resp = 0, rst_zero = 0, e_legal = 0;
    logic [31:0] ma, md;
    logic [3:0] ms;
    logic [1:0] e_bresp = 2'b00;
    logic [3:0] e_idx = '0;
    logic [31:0] e_data = '0;
    logic [3:0] e_strb = '0;
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, a, e, cyc);
        end
    endtask
    initial forever begin
        @(posedge clk);
        cyc++;
        if (areset) begin
            m_init = 1; up = 0; ha = 0; hw = 0; in_resp = 0; done_at = -1;
            e_bresp = 2'b00; rst_zero = 1; e_idx = '0; e_data = '0; e_strb = '0;
        end else begin
            if (in_resp) begin
                if (bready) begin
                    in_resp = 0; ha = 0; hw = 0; done_at = -1;
                end
            end else if (done_at >= 0) begin
                e_bresp = (!e_legal || reg_wr_err) ? 2'b10 : 2'b00;
                in_resp = 1;
            end else if (up) begin
                if (awvalid && !ha) begin ha = 1; ma = awaddr; end
                if (wvalid && !hw) begin hw = 1; md = wdata; ms = wstrb; end
                if (ha && hw) begin
                    done_at = cyc;
                    e_legal = (ma % 4 == 0) && (ma / 4 < 16);
                    e_idx = 4'((ma / 4) % 16);
                    e_data = md;
                    e_strb = ms;
                    rst_zero = 0;
                end
            end
            up = 1;
        end
    end
    initial forever begin
        @(negedge clk);
        if (m_init) begin
            chk("awready", awready, up && done_at < 0 && !ha);
            chk("wready", wready, up && done_at < 0 && !hw);
            chk("reg_wr_en", reg_wr_en, done_at == cyc && e_legal);
            chk("bvalid", bvalid, in_resp);
            chk("bresp", bresp, e_bresp);
            if ((done_at == cyc && e_legal) || rst_zero) begin
                chk("reg_wr_idx", reg_wr_idx, e_idx);
                chk("reg_wr_data", reg_wr_data, e_data);
                chk("reg_wr_strb", reg_wr_strb, e_strb);
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s;
        tick();
        awvalid = 0; wvalid = 0;
    endtask
    function automatic logic [31:0] rand_addr();
        int k = $urandom_range(0, 9);
        logic [31:0] a = 32'($urandom_range(0, 15)) << 2;
        if (k == 7) a = a | 32'($urandom_range(1, 3));
        if (k == 8) a = 32'h40 + (32'($urandom_range(0, 63)) << 2);
        if (k == 9) a = $urandom;
        return a;
    endfunction
    bit aw_fire, w_fire;
    initial begin
        repeat (3) tick();
        areset = 0;
        tick();
        wr(32'h08, 32'hDEADBEEF, 4'hF);
        chk("t1_en", reg_wr_en, 1);
        chk("t1_idx", reg_wr_idx, 2);
        chk("t1_data", reg_wr_data, 32'hDEADBEEF);
        tick();
        chk("t1_bvalid", bvalid, 1);
        chk("t1_bresp", bresp, 0);
        repeat (2) tick();
        wvalid = 1; wdata = 32'h12345678; wstrb = 4'h3;
        tick();
        wvalid = 0;
        chk("t2_wready", wready, 0);
        repeat (2) tick();
        awvalid = 1; awaddr = 32'h3C;
        tick();
        awvalid = 0;
        chk("t2_en", reg_wr_en, 1);
        chk("t2_idx", reg_wr_idx, 15);
        chk("t2_strb", reg_wr_strb, 4'h3);
        tick();
        chk("t2_bresp", bresp, 0);
        repeat (2) tick();
        for (int i = 0; i < 2; i++) begin
            wr(i == 0 ? 32'h40 : 32'h06, 32'hA5A5A5A5, 4'hF);
            chk("t3_en", reg_wr_en, 0);
            tick();
            chk("t3_bvalid", bvalid, 1);
            chk("t3_bresp", bresp, 2'b10);
            repeat (2) tick();
        end
        bready = 0;
        wr(32'h04, 32'h0, 4'h0);
        chk("t4_en_strb0", reg_wr_en, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4_bvalid", bvalid, 1);
            chk("t4_bresp", bresp, 0);
            chk("t4_awready", awready, 0);
            chk("t4_wready", wready, 0);
            tick();
        end
        bready = 1;
        tick();
        chk("t4_idle_awready", awready, 1);
        chk("t4_idle_bvalid", bvalid, 0);
        reg_wr_err = 1;
        wr(32'h00, 32'h1, 4'h1);
        chk("t5_en", reg_wr_en, 1);
        tick();
        reg_wr_err = 0;
        chk("t5_bresp", bresp, 2'b10);
        repeat (2) tick();
        wr(32'h0C, 32'h2, 4'hF);
        areset = 1;
        tick();
        areset = 0;
        chk("t6w_en", reg_wr_en, 0);
        chk("t6w_bvalid", bvalid, 0);
        chk("t6w_awready", awready, 0);
        tick();
        chk("t6w_awready_up", awready, 1);
        bready = 0;
        wr(32'h08, 32'h3, 4'hF);
        tick();
        areset = 1;
        tick();
        areset = 0;
        bready = 1;
        chk("t6r_bvalid", bvalid, 0);
        chk("t6r_bresp", bresp, 0);
        repeat (2) tick();
        chk("t6r_no_bvalid", bvalid, 0);
        wr(32'h10, 32'hCAFEF00D, 4'hC);
        chk("t6_new_en", reg_wr_en, 1);
        chk("t6_new_idx", reg_wr_idx, 4);
        tick();
        chk("t6_new_bresp", bresp, 0);
        tick();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            aw_fire = awvalid && awready;
            w_fire = wvalid && wready;
            tick();
            if (aw_fire || !awvalid || areset) begin
                awvalid = $urandom_range(0, 2) == 0;
                awaddr = rand_addr();
            end
            if (w_fire || !wvalid || areset) begin
                wvalid = $urandom_range(0, 2) == 0;
                wdata = $urandom;
                wstrb = 4'($urandom_range(0, 15));
            end
            bready = $urandom_range(0, 3) != 0;
            reg_wr_err = $urandom_range(0, 3) == 0;
            areset = $urandom_range(0, 199) == 0;
        end
        areset = 0; awvalid = 0; wvalid = 0;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
